inst_encoder: RTL and testbench
===============================

INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst_n  input  1  reset, asynchronous, active-low.
REQ-003 in_valid  input  1  command present.
REQ-004 in_ready  output  1  encoder can accept a command this cycle.
REQ-005 in_code  input  5  mnemonic code, table in REQ-014.
REQ-006 in_rs, in_rt, in_rd, in_shamt  input  5 each  register/shift fields.
REQ-007 in_imm  input  16  immediate/offset; in_target input 26 jump target.
REQ-008 addr_load  input  1  load write pointer from addr_val (honoured only in IDLE).
REQ-009 addr_val  input  10  word address to load.
REQ-010 im_we  output  1  instruction-memory write strobe.
REQ-011 im_addr  output  10  word address of write; im_wdata output 32 encoded instruction.
REQ-012 im_stall  input  1  memory busy; write completes only in a cycle with im_we=1 and im_stall=0.
REQ-013 err  output  1  sticky illegal-code flag; word_cnt output 11 count of completed writes.

Function
REQ-014 Codes: 0 nop (32'h0); R-type op 000000 funct: 1 add 100000, 2 sub 100010, 3 subu 100011, 4 and 100100, 5 or 100101, 6 xor 100110, 7 nor 100111, 8 slt 101010, 9 sltu 101011, 10 sll 000000, 11 srl 000010, 12 sra 000011, 13 jr 001000, 14 jalr 001001; I-type op: 15 addi 001000, 16 addiu 001001, 17 slti 001010, 18 sltiu 001011, 19 andi 001100, 20 ori 001101, 21 xori 001110, 22 lui 001111, 23 lw 100011, 24 sw 101011, 25 beq 000100, 26 bne 000101; J-type op: 27 j 000010, 28 jal 000011; 29-31 illegal.
REQ-015 R-type word SHALL be {op,rs,rt,rd,shamt,funct}; shamt field forced 0 except sll/srl/sra; rd forced 0 for jr; rs forced 0 for sll/srl/sra; rt forced 0 for jr/jalr.
REQ-016 I-type word SHALL be {op,rs,rt,imm}; rs forced 0 for lui.
REQ-017 J-type word SHALL be {op,target}.
REQ-018 States: IDLE, WRITE. in_ready=1 only in IDLE.
REQ-019 IDLE, in_valid=1, legal code: word registered into im_wdata, im_addr=pointer, next state WRITE.
REQ-020 IDLE, in_valid=1, illegal code: command consumed, err set to 1, no write, stay IDLE.
REQ-021 WRITE: im_we=1, im_addr/im_wdata held stable while im_stall=1; on im_stall=0 the write completes, pointer increments, word_cnt increments, next state IDLE.
REQ-022 Latency: command accepted at edge N -> im_we=1 in cycle after edge N; minimum two cycles per command (one IDLE, one WRITE).
REQ-023 Pointer wraps 1023 -> 0; word_cnt saturates at 1024.
REQ-024 addr_load in IDLE same cycle as in_valid: load takes effect first; accepted command writes to addr_val. addr_load in WRITE ignored.
REQ-025 im_we=0 in IDLE; err cleared only by reset.

Reset
REQ-026 rst_n=0 SHALL immediately force: state IDLE, in_ready=1 after release, im_we=0, im_addr=0, im_wdata=0, pointer=0, word_cnt=0, err=0.
REQ-027 Reset asserted during WRITE SHALL abort the write with no completion counted.

Verification
REQ-028 Reset, add rs=1 rt=2 rd=3 -> im_we next cycle, im_addr=0, im_wdata=32'h00221820, word_cnt=1.
REQ-029 addiu rs=0 rt=8 imm=16'hFFFF, im_stall high 3 cycles -> im_we held 4 cycles, word 32'h2408FFFF stable, one count.
REQ-030 Code 30 -> err=1, no im_we, in_ready=1 next cycle; following lui rt=4 imm=16'h1234 -> 32'h3C041234.
REQ-031 addr_load addr_val=1023 with jal target=26'h0000010 -> write at 1023 word 32'h0C000010; next command writes address 0.
REQ-032 Back-to-back in_valid held high for 4 sll commands (rt=2 rd=2 shamt=4, rs input 7) -> four writes, each 32'h00021100, in_ready toggles 1/0, word_cnt=4.
REQ-033 Reset asserted mid-WRITE with im_stall=1 -> im_we=0 immediately, word_cnt=0, im_addr=0.

Source files
------------

// File: rtl/inst_encoder.sv
// Instruction encoder: turns mnemonic commands into 32-bit MIPS-style words and
// writes them into instruction memory at an auto-incrementing word pointer.
module inst_encoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_code,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_shamt,
  input  logic [15:0] in_imm,
  input  logic [25:0] in_target,
  input  logic        addr_load,
  input  logic [9:0]  addr_val,
  output logic        im_we,
  output logic [9:0]  im_addr,
  output logic [31:0] im_wdata,
  input  logic        im_stall,
  output logic        err,
  output logic [10:0] word_cnt
);

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StWrite = 1'b1;

  localparam logic [1:0] KindNop = 2'd0;
  localparam logic [1:0] KindR   = 2'd1;
  localparam logic [1:0] KindI   = 2'd2;
  localparam logic [1:0] KindJ   = 2'd3;

  localparam logic [10:0] CntMax = 11'd1024;

  logic [0:0]  state_q, state_d;
  logic [9:0]  ptr_q, ptr_d;
  logic [10:0] cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [9:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  logic [1:0]  enc_kind;
  logic [5:0]  enc_op;
  logic [5:0]  enc_funct;
  logic        enc_legal;
  logic [31:0] enc_word;

  // Mnemonic decode: instruction format, opcode and funct.
  always_comb begin
    enc_kind  = KindNop;
    enc_op    = 6'b000000;
    enc_funct = 6'b000000;
    enc_legal = 1'b1;
    case (in_code)
      5'd0:  enc_kind = KindNop;
      5'd1:  begin enc_kind = KindR; enc_funct = 6'b100000; end
      5'd2:  begin enc_kind = KindR; enc_funct = 6'b100010; end
      5'd3:  begin enc_kind = KindR; enc_funct = 6'b100011; end
      5'd4:  begin enc_kind = KindR; enc_funct = 6'b100100; end
      5'd5:  begin enc_kind = KindR; enc_funct = 6'b100101; end
      5'd6:  begin enc_kind = KindR; enc_funct = 6'b100110; end
      5'd7:  begin enc_kind = KindR; enc_funct = 6'b100111; end
      5'd8:  begin enc_kind = KindR; enc_funct = 6'b101010; end
      5'd9:  begin enc_kind = KindR; enc_funct = 6'b101011; end
      5'd10: begin enc_kind = KindR; enc_funct = 6'b000000; end
      5'd11: begin enc_kind = KindR; enc_funct = 6'b000010; end
      5'd12: begin enc_kind = KindR; enc_funct = 6'b000011; end
      5'd13: begin enc_kind = KindR; enc_funct = 6'b001000; end
      5'd14: begin enc_kind = KindR; enc_funct = 6'b001001; end
      5'd15: begin enc_kind = KindI; enc_op = 6'b001000; end
      5'd16: begin enc_kind = KindI; enc_op = 6'b001001; end
      5'd17: begin enc_kind = KindI; enc_op = 6'b001010; end
      5'd18: begin enc_kind = KindI; enc_op = 6'b001011; end
      5'd19: begin enc_kind = KindI; enc_op = 6'b001100; end
      5'd20: begin enc_kind = KindI; enc_op = 6'b001101; end
      5'd21: begin enc_kind = KindI; enc_op = 6'b001110; end
      5'd22: begin enc_kind = KindI; enc_op = 6'b001111; end
      5'd23: begin enc_kind = KindI; enc_op = 6'b100011; end
      5'd24: begin enc_kind = KindI; enc_op = 6'b101011; end
      5'd25: begin enc_kind = KindI; enc_op = 6'b000100; end
      5'd26: begin enc_kind = KindI; enc_op = 6'b000101; end
      5'd27: begin enc_kind = KindJ; enc_op = 6'b000010; end
      5'd28: begin enc_kind = KindJ; enc_op = 6'b000011; end
      default: enc_legal = 1'b0;
    endcase
  end

  logic is_shift, is_jr, is_jalr, is_lui;
  assign is_shift = (in_code == 5'd10) || (in_code == 5'd11) || (in_code == 5'd12);
  assign is_jr    = (in_code == 5'd13);
  assign is_jalr  = (in_code == 5'd14);
  assign is_lui   = (in_code == 5'd22);

  // Word assembly; unused fields are zeroed so the encoding is canonical.
  always_comb begin
    enc_word = 32'h0000_0000;
    case (enc_kind)
      KindR: enc_word = {6'b000000,
                         is_shift ? 5'd0 : in_rs,
                         (is_jr || is_jalr) ? 5'd0 : in_rt,
                         is_jr ? 5'd0 : in_rd,
                         is_shift ? in_shamt : 5'd0,
                         enc_funct};
      KindI: enc_word = {enc_op, is_lui ? 5'd0 : in_rs, in_rt, in_imm};
      KindJ: enc_word = {enc_op, in_target};
      default: enc_word = 32'h0000_0000;
    endcase
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (state_q == StIdle) begin
      if (addr_load) ptr_d = addr_val;
      if (in_valid) begin
        if (enc_legal) begin
          // A same-cycle pointer load takes effect before the accepted write.
          addr_d  = addr_load ? addr_val : ptr_q;
          wdata_d = enc_word;
          state_d = StWrite;
        end else begin
          err_d = 1'b1;
        end
      end
    end else begin
      if (!im_stall) begin
        ptr_d   = ptr_q + 10'd1;
        cnt_d   = (cnt_q == CntMax) ? cnt_q : cnt_q + 11'd1;
        state_d = StIdle;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ptr_q   <= 10'd0;
      cnt_q   <= 11'd0;
      err_q   <= 1'b0;
      addr_q  <= 10'd0;
      wdata_q <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign in_ready = (state_q == StIdle);
  assign im_we    = (state_q == StWrite);
  assign im_addr  = addr_q;
  assign im_wdata = wdata_q;
  assign err      = err_q;
  assign word_cnt = cnt_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Scoreboard bench for inst_encoder: stimulus pushes expected writes, a monitor
// pops and compares each memory write as the DUT presents it.
module tb_inst_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_code, in_rs, in_rt, in_rd, in_shamt;
  logic [15:0] in_imm;
  logic [25:0] in_target;
  logic        addr_load;
  logic [9:0]  addr_val;
  logic        im_we;
  logic [9:0]  im_addr;
  logic [31:0] im_wdata;
  logic        im_stall;
  logic        err;
  logic [10:0] word_cnt;

  typedef struct packed {
    logic [9:0]  addr;
    logic [31:0] word;
  } exp_t;

  exp_t        sb_q[$];
  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [9:0]  exp_ptr;

  always #5 clk = ~clk;

  inst_encoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_code   (in_code),
    .in_rs     (in_rs),
    .in_rt     (in_rt),
    .in_rd     (in_rd),
    .in_shamt  (in_shamt),
    .in_imm    (in_imm),
    .in_target (in_target),
    .addr_load (addr_load),
    .addr_val  (addr_val),
    .im_we     (im_we),
    .im_addr   (im_addr),
    .im_wdata  (im_wdata),
    .im_stall  (im_stall),
    .err       (err),
    .word_cnt  (word_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] word);
    exp_t e;
    e.addr = exp_ptr;
    e.word = word;
    sb_q.push_back(e);
    exp_ptr++;
  endtask

  // Monitor: every write cycle must match the queue head; a stalled write stays put.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && im_we) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_write: addr %h data %h with nothing expected", im_addr,
                   im_wdata);
        end else begin
          check("wr_addr", {22'b0, im_addr}, {22'b0, sb_q[0].addr});
          check("wr_data", im_wdata, sb_q[0].word);
          if (!im_stall) void'(sb_q.pop_front());
        end
      end
    end
  end

  task automatic send(input logic [4:0] code, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                      input logic [25:0] tgt, input logic [31:0] exp_word, input int stall,
                      input logic load, input logic [9:0] lval);
    int budget;
    budget = 0;
    @(negedge clk);
    while (!in_ready && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    if (!in_ready) check("ready_wait", {31'b0, in_ready}, 32'd1);
    in_code   = code;
    in_rs     = rs;
    in_rt     = rt;
    in_rd     = rd;
    in_shamt  = sh;
    in_imm    = imm;
    in_target = tgt;
    addr_load = load;
    addr_val  = lval;
    im_stall  = (stall > 0);
    in_valid  = 1'b1;
    if (load) exp_ptr = lval;
    push_exp(exp_word);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    addr_load = 1'b0;
    @(negedge clk);
    check("we_latency", {31'b0, im_we}, 32'd1);
    check("ready_low", {31'b0, in_ready}, 32'd0);
    for (int k = 1; k <= stall; k++) begin
      @(posedge clk);
      #1;
      if (k == stall) im_stall = 1'b0;
      @(negedge clk);
      check("we_held", {31'b0, im_we}, 32'd1);
    end
    budget = 0;
    @(negedge clk);
    while (!in_ready && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    check("done_ready", {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_code = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_shamt = '0;
    in_imm = '0; in_target = '0; addr_load = 1'b0; addr_val = '0; im_stall = 1'b0;
    exp_ptr = '0;
    #12;
    check("rst_we", {31'b0, im_we}, 32'd0);
    check("rst_addr", {22'b0, im_addr}, 32'd0);
    check("rst_wdata", im_wdata, 32'd0);
    check("rst_cnt", {21'b0, word_cnt}, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", {31'b0, in_ready}, 32'd1);

    // add rs=1 rt=2 rd=3, shamt input ignored
    send(5'd1, 5'd1, 5'd2, 5'd3, 5'd5, 16'h0, 26'h0, 32'h0022_1820, 0, 1'b0, 10'd0);
    check("cnt_add", {21'b0, word_cnt}, 32'd1);

    // addiu with three stall cycles: four write cycles, one count
    send(5'd16, 5'd0, 5'd8, 5'd0, 5'd0, 16'hFFFF, 26'h0, 32'h2408_FFFF, 3, 1'b0, 10'd0);
    check("cnt_addiu", {21'b0, word_cnt}, 32'd2);

    // illegal code: consumed, err set, no write
    in_code = 5'd30;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("ill_err", {31'b0, err}, 32'd1);
    check("ill_we", {31'b0, im_we}, 32'd0);
    check("ill_ready", {31'b0, in_ready}, 32'd1);
    check("ill_cnt", {21'b0, word_cnt}, 32'd2);

    // lui: rs input forced to zero
    send(5'd22, 5'd9, 5'd4, 5'd0, 5'd0, 16'h1234, 26'h0, 32'h3C04_1234, 0, 1'b0, 10'd0);
    check("err_sticky", {31'b0, err}, 32'd1);

    // jal at loaded address 1023, then pointer wraps to 0
    send(5'd28, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h000_0010, 32'h0C00_0010, 0, 1'b1, 10'd1023);
    send(5'd5, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 32'h0022_1825, 0, 1'b0, 10'd0);
    check("cnt_or", {21'b0, word_cnt}, 32'd5);

    // reset in the middle of a stalled write
    @(negedge clk);
    in_code = 5'd2; in_rs = 5'd1; in_rt = 5'd2; in_rd = 5'd3; in_shamt = 5'd0;
    im_stall = 1'b1;
    in_valid = 1'b1;
    push_exp(32'h0022_1822);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("mid_we", {31'b0, im_we}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_we", {31'b0, im_we}, 32'd0);
    check("abort_cnt", {21'b0, word_cnt}, 32'd0);
    check("abort_addr", {22'b0, im_addr}, 32'd0);
    check("abort_err", {31'b0, err}, 32'd0);
    sb_q.delete();
    exp_ptr = '0;
    im_stall = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // four back-to-back sll with in_valid held high
    in_code = 5'd10; in_rs = 5'd7; in_rt = 5'd2; in_rd = 5'd2; in_shamt = 5'd4;
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("b2b_ready", {31'b0, in_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
      if (i % 2 == 0) push_exp(32'h0002_1100);
      @(posedge clk);
      #1;
      if (i == 6) in_valid = 1'b0;
    end
    @(negedge clk);
    check("cnt_b2b", {21'b0, word_cnt}, 32'd4);

    // jr: rt, rd, shamt forced to zero; sw: plain I-type
    send(5'd13, 5'd5, 5'd6, 5'd7, 5'd3, 16'h0, 26'h0, 32'h00A0_0008, 1, 1'b0, 10'd0);
    send(5'd24, 5'd29, 5'd31, 5'd0, 5'd0, 16'h0004, 26'h0, 32'hAFBF_0004, 0, 1'b0, 10'd0);
    check("cnt_final", {21'b0, word_cnt}, 32'd6);
    check("err_final", {31'b0, err}, 32'd0);
    check("sb_empty", sb_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
